// File: rtl/wb_buffer.sv
// wb_buffer: writeback buffer in front of the register file write port.
//
// Producers push (addr, data) through in_valid/in_ready into an in-order FIFO.
// One entry is popped per clock into the registered write port
// (wr_en/wr_addr/wr_data) unless drain_hold is high. count is the FIFO
// occupancy and does not include the output stage.
//
// Optional feature macro WB_BYPASS_EN: when defined, lk_addr1/2 search the
// pending FIFO entries and the output stage (when wr_en=1) for the youngest
// write to that address. When undefined, lk_hit*/lk_data* are tied to 0.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     push handshake; in_addr/in_data carry the result
//   drain_hold            high suppresses the pop on that edge
//   wr_en/wr_addr/wr_data registered register file write port
//   count                 FIFO occupancy
//   lk_addr*/lk_hit*/lk_data*  bypass lookup (combinational)
module wb_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drain_hold,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] lk_addr1,
  input  logic [ADDR_W-1:0] lk_addr2,
  output logic              lk_hit1,
  output logic              lk_hit2,
  output logic [DATA_W-1:0] lk_data1,
  output logic [DATA_W-1:0] lk_data2
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [ADDR_W-1:0] mem_addr_d [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [DATA_W-1:0] mem_data_d [DEPTH];
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              push_en, pop_en;

  // Depends only on registered count: no path from in_valid or drain_hold.
  assign in_ready = (count_q != CNT_W'(DEPTH));

  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    // Pop uses pre-edge count, so a push into an empty FIFO is not popped
    // on the same edge; a full FIFO never accepts, even with a pop.
    pop_en     = (count_q != '0) && !drain_hold;
    push_en    = in_valid && in_ready;
    wr_en_d    = pop_en;
    if (pop_en) begin
      wr_addr_d = mem_addr_q[head_q];
      wr_data_d = mem_data_q[head_q];
      head_d    = head_q + PtrW'(1);
    end
    if (push_en) begin
      mem_addr_d[tail_q] = in_addr;
      mem_data_d[tail_q] = in_data;
      tail_d             = tail_q + PtrW'(1);
    end
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_addr_q[i] <= '0;
        mem_data_q[i] <= '0;
      end
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign count   = count_q;

`ifdef WB_BYPASS_EN
  logic [PtrW-1:0] idx;

  // Walk oldest to youngest so later matches overwrite earlier ones; the
  // output stage is older than every FIFO entry, so it is checked first.
  always_comb begin
    lk_hit1  = 1'b0;
    lk_hit2  = 1'b0;
    lk_data1 = '0;
    lk_data2 = '0;
    idx      = head_q;
    if (wr_en_q && (wr_addr_q == lk_addr1)) begin
      lk_hit1  = 1'b1;
      lk_data1 = wr_data_q;
    end
    if (wr_en_q && (wr_addr_q == lk_addr2)) begin
      lk_hit2  = 1'b1;
      lk_data2 = wr_data_q;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if (CNT_W'(i) < count_q) begin
        if (mem_addr_q[idx] == lk_addr1) begin
          lk_hit1  = 1'b1;
          lk_data1 = mem_data_q[idx];
        end
        if (mem_addr_q[idx] == lk_addr2) begin
          lk_hit2  = 1'b1;
          lk_data2 = mem_data_q[idx];
        end
      end
    end
  end
`else
  logic unused_lk;
  assign unused_lk = ^{lk_addr1, lk_addr2};
  assign lk_hit1   = 1'b0;
  assign lk_hit2   = 1'b0;
  assign lk_data1  = '0;
  assign lk_data2  = '0;
`endif

endmodule
